effective_address_unit: RTL and testbench

Computes the PDP-8 effective address (EA) for a memory-reference instruction. Direct page-zero and current-page addressing are resolved with no memory traffic. Indirect addressing and auto-index (locations 0010–0017 octal) are resolved by driving the master side of `memory_pins` into `memory_controller`. It sits between the CPU execute sequencer, which issues `start`, and the memory controller, which it owns during indirection.

---
 rtl/effective_address_unit_pkg.sv | 38 +++
 rtl/memory_pins.sv | 19 +
 rtl/effective_address_unit.sv | 82 ++++++++
 tb/tb_effective_address_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/effective_address_unit_pkg.sv
// effective_address_unit_pkg: CPU word definitions and the EA unit's state
// encoding, auto-index window and instruction field helpers.
package CPU_Definitions;
    typedef logic [11:0] word;
    localparam logic DATA_READ = 1'b0;
endpackage

package ea_defs;
    import CPU_Definitions::*;

    typedef enum logic [2:0] {
        EA_IDLE,
        EA_ISSUE_RD,
        EA_WAIT_RD,
        EA_ISSUE_WR,
        EA_WAIT_WR,
        EA_DONE
    } ea_state_t;

    localparam word AUTOINDEX_LO = 12'o0010;
    localparam word AUTOINDEX_HI = 12'o0017;

    function automatic logic [2:0] get_opcode(input word i);
        return i[11:9];
    endfunction

    function automatic logic get_ibit(input word i);
        return i[8];
    endfunction

    function automatic logic get_zbit(input word i);
        return i[7];
    endfunction

    function automatic logic [6:0] get_offset(input word i);
        return i[6:0];
    endfunction
endpackage

// File: rtl/memory_pins.sv
// memory_pins: request/response wires between a memory master and the memory controller.
interface memory_pins;
    import CPU_Definitions::*;
    word  address;
    word  write_data;
    word  read_data;
    logic read_enable;
    logic write_enable;
    logic mem_finished;

    modport master (
        output address, write_data, read_enable, write_enable,
        input  read_data, mem_finished
    );
    modport slave (
        input  address, write_data, read_enable, write_enable,
        output read_data, mem_finished
    );
endinterface

// File: rtl/effective_address_unit.sv
// effective_address_unit: resolves the PDP-8 effective address, walking indirect
// and auto-index pointers through the memory controller when needed.
module effective_address_unit
    import CPU_Definitions::*;
    import ea_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  word        instr,
    input  word        pc,
    output word        ea,
    output logic       done,
    output logic       busy,
    output logic       read_type,
    memory_pins.master pins
);
    ea_state_t r_state, w_next;
    word       r_ea, r_addr, r_wdata;
    logic      r_auto, r_fin_q;
    word       w_direct;
    logic      w_nonmri, w_indirect, w_fin, w_accept;

    // Masking pc keeps the page bits and discards the in-page part.
    assign w_direct   = get_zbit(instr) ? ((pc & 12'o7600) | {5'b0, get_offset(instr)})
                                        : {5'b0, get_offset(instr)};
    assign w_nonmri   = get_opcode(instr) >= 3'd6;
    assign w_indirect = !w_nonmri && get_ibit(instr);
    assign w_accept   = (r_state == EA_IDLE) && start;
    assign w_fin      = pins.mem_finished && !r_fin_q;

    always_comb begin
        w_next = r_state;
        case (r_state)
            EA_IDLE:     w_next = start ? (w_indirect ? EA_ISSUE_RD : EA_DONE) : EA_IDLE;
            EA_ISSUE_RD: w_next = EA_WAIT_RD;
            EA_WAIT_RD:  w_next = w_fin ? (r_auto ? EA_ISSUE_WR : EA_DONE) : EA_WAIT_RD;
            EA_ISSUE_WR: w_next = EA_WAIT_WR;
            EA_WAIT_WR:  w_next = w_fin ? EA_DONE : EA_WAIT_WR;
            default:     w_next = EA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= EA_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ea    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_auto  <= 1'b0;
            r_fin_q <= 1'b0;
        end else begin
            r_fin_q <= pins.mem_finished;
            if (w_accept) begin
                r_ea <= w_nonmri ? '0 : w_direct;
                if (w_indirect) begin
                    r_addr <= w_direct;
                    r_auto <= (w_direct >= AUTOINDEX_LO) && (w_direct <= AUTOINDEX_HI);
                end
            end
            if (r_state == EA_WAIT_RD && w_fin) begin
                r_ea    <= r_auto ? pins.read_data + 12'd1 : pins.read_data;
                r_wdata <= pins.read_data + 12'd1;
            end
        end
    end

    assign ea                = r_ea;
    assign done              = r_state == EA_DONE;
    assign busy              = r_state != EA_IDLE;
    assign read_type         = DATA_READ;
    assign pins.address      = r_addr;
    assign pins.write_data   = r_wdata;
    assign pins.read_enable  = r_state == EA_ISSUE_RD;
    assign pins.write_enable = r_state == EA_ISSUE_WR;
endmodule

// File: tb/tb_effective_address_unit.sv
// tb_effective_address_unit: directed and random EA resolutions against a
// behavioural memory with programmable latency and an arithmetic EA model.
module tb_effective_address_unit;
    import CPU_Definitions::*;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    word  instr = '0, pc = '0, ea;
    logic done, busy, read_type;

    memory_pins pins ();

    effective_address_unit dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
        .ea(ea), .done(done), .busy(busy), .read_type(read_type), .pins(pins)
    );

    always #5 clk = ~clk;

    word  mem [4096];
    logic ld_en = 1'b0, hold_fin = 1'b0;
    word  ld_addr = '0, ld_data = '0;
    int   lat_lo = 1, lat_hi = 1;
    logic pend = 1'b0, pend_wr = 1'b0;
    word  pend_addr = '0, pend_data = '0;
    int   lat = 0;
    int   rd_cnt = 0, wr_cnt = 0, done_cnt = 0, bad_type = 0, bad_both = 0, bad_stab = 0;
    word  last_rd = '0, last_wr = '0;
    int   n_vec = 0, n_err = 0;

    // Memory: a request seen at edge E completes with a one-cycle finish pulse at edge E+lat.
    always @(posedge clk) begin
        pins.mem_finished <= hold_fin;
        if (ld_en) mem[ld_addr] <= ld_data;
        if (pins.read_enable || pins.write_enable) begin
            pend      <= 1'b1;
            pend_wr   <= pins.write_enable;
            pend_addr <= pins.address;
            pend_data <= pins.write_data;
            lat       <= $urandom_range(lat_hi, lat_lo);
        end else if (pend) begin
            if (lat <= 1) begin
                pend              <= 1'b0;
                pins.mem_finished <= 1'b1;
                if (pend_wr) mem[pend_addr] <= pend_data;
                else pins.read_data <= mem[pend_addr];
            end else begin
                lat <= lat - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (pins.read_enable) begin
            rd_cnt  <= rd_cnt + 1;
            last_rd <= pins.address;
            if (read_type !== DATA_READ) bad_type <= bad_type + 1;
        end
        if (pins.write_enable) begin
            wr_cnt  <= wr_cnt + 1;
            last_wr <= pins.address;
        end
        if (pins.read_enable && pins.write_enable) bad_both <= bad_both + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (pend && busy && (pins.address !== pend_addr || (pend_wr && pins.write_data !== pend_data)))
            bad_stab <= bad_stab + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic poke(input word a, input word v);
        ld_addr = a;
        ld_data = v;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // EA rules computed with plain arithmetic on octal fields.
    task automatic model(input word ins, input word p, input word ptr, output word d,
                         output word exp_ea, output int n_rd, output int n_wr);
        int opc = int'(ins) / 512;
        int ib  = (int'(ins) / 256) % 2;
        int zb  = (int'(ins) / 128) % 2;
        int off = int'(ins) % 128;
        int da  = zb ? (int'(p) / 128) * 128 + off : off;
        d    = word'(da);
        n_rd = 0;
        n_wr = 0;
        if (opc >= 6) exp_ea = '0;
        else if (ib == 0) exp_ea = d;
        else begin
            n_rd = 1;
            if (da >= 8 && da <= 15) begin
                n_wr   = 1;
                exp_ea = word'((int'(ptr) + 1) % 4096);
            end else begin
                exp_ea = ptr;
            end
        end
    endtask

    task automatic do_op(input word ins, input word p, input word ptr, input int lat_cyc, input bit extra);
        word d, exp_ea;
        int  n_rd, n_wr, r0, w0, d0, cyc, exp_lat;
        model(ins, p, ptr, d, exp_ea, n_rd, n_wr);
        lat_lo = lat_cyc;
        lat_hi = lat_cyc;
        if (n_rd != 0) poke(d, ptr);
        // Memory answers lat_cyc+1 cycles after the request cycle.
        exp_lat = (n_rd == 0) ? 1 : 2 + (lat_cyc + 1) + ((n_wr != 0) ? 1 + lat_cyc + 1 : 0);
        r0 = rd_cnt;
        w0 = wr_cnt;
        d0 = done_cnt;
        chk("done_at_start", done, 0);
        start = 1'b1;
        instr = ins;
        pc    = p;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            start = extra && cyc == 2;
            if (start) instr = 12'o1123;
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("ea", ea, exp_ea);
        chk("latency", cyc, exp_lat);
        chk("busy_in_done", busy, 1);
        @(posedge clk);
        #1 chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        repeat (3) @(posedge clk);
        #1 chk("reads", rd_cnt - r0, n_rd);
        chk("writes", wr_cnt - w0, n_wr);
        chk("done_count", done_cnt - d0, 1);
        if (n_rd != 0) chk("rd_addr", last_rd, d);
        if (n_wr != 0) begin
            chk("wr_addr", last_wr, d);
            chk("mem_writeback", mem[d], exp_ea);
        end else if (n_rd != 0) begin
            chk("mem_kept", mem[d], ptr);
        end
    endtask

    initial begin
        word r_ins, r_pc, r_ptr;
        int  cyc, w0, d0;
        repeat (3) @(posedge clk);
        #1 chk("rst_ea", ea, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", pins.address, 0);
        chk("rst_wdata", pins.write_data, 0);
        chk("rst_re", pins.read_enable, 0);
        chk("rst_we", pins.write_enable, 0);
        reset = 1'b0;

        do_op(12'o1123, 12'o4200, 12'o0000, 1, 1'b0);
        do_op(12'o1323, 12'o4200, 12'o0000, 1, 1'b0);
        do_op(12'o1523, 12'o4200, 12'o2345, 3, 1'b0);
        do_op(12'o1410, 12'o4200, 12'o0777, 3, 1'b0);
        do_op(12'o1417, 12'o4200, 12'o7777, 2, 1'b0);
        do_op(12'o7001, 12'o4200, 12'o0000, 1, 1'b0);
        do_op(12'o1523, 12'o4200, 12'o1234, 4, 1'b1);
        do_op(12'o3610, 12'o0055, 12'o0100, 1, 1'b0);

        // A finish line already high when the read is issued must not complete it.
        lat_lo = 6;
        lat_hi = 6;
        poke(12'o0123, 12'o3210);
        hold_fin = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        instr = 12'o1523;
        pc    = 12'o4200;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 hold_fin = 1'b0;
        cyc = 2;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("stale_ea", ea, 12'o3210);
        chk("stale_latency", cyc, 9);
        repeat (3) @(posedge clk);

        // Reset while waiting for the auto-index read: no write-back may follow.
        lat_lo = 3;
        lat_hi = 3;
        poke(12'o0010, 12'o0555);
        w0 = wr_cnt;
        d0 = done_cnt;
        start = 1'b1;
        instr = 12'o1410;
        pc    = 12'o4200;
        @(posedge clk);
        #1 start = 1'b0;
        chk("rst_mid_re", pins.read_enable, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_re_off", pins.read_enable, 0);
        chk("rst_mid_we_off", pins.write_enable, 0);
        repeat (8) @(posedge clk);
        #1 chk("rst_mid_writes", wr_cnt - w0, 0);
        chk("rst_mid_dones", done_cnt - d0, 0);
        chk("rst_mid_mem", mem[12'o0010], 12'o0555);
        do_op(12'o1123, 12'o4200, 12'o0000, 1, 1'b0);

        for (int k = 0; k < 60; k++) begin
            r_ins = word'($urandom);
            r_pc  = word'($urandom);
            r_ptr = word'($urandom);
            if ($urandom_range(0, 2) == 0)
                r_ins = {3'($urandom_range(0, 5)), 2'b10, 7'($urandom_range(8, 15))};
            do_op(r_ins, r_pc, r_ptr, $urandom_range(1, 4), k % 5 == 0 && r_ins[8] && r_ins[11:9] < 3'd6);
        end

        chk("read_type", bad_type, 0);
        chk("re_we_overlap", bad_both, 0);
        chk("addr_stable", bad_stab, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
